// File: rtl/multi_debouncer.sv
// N-channel button debouncer: 2-flop sync, stability counter, press/release/long-press strobes.
// Optional auto-repeat strobes after a long press are built only when DEBOUNCE_REPEAT_EN is defined.
module multi_debouncer #(
    parameter int CHANNELS        = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 100000000,
    parameter int REPEAT_CYCLES   = 20000000,
    parameter int ACTIVE_LOW_IN   = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] button_in,
    output logic [CHANNELS-1:0] btn_out,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_pulse,
    output logic [CHANNELS-1:0] repeat_pulse,
    output logic                any_active
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic          INVERT    = (ACTIVE_LOW_IN != 0);

`ifdef DEBOUNCE_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
`endif

    if (CHANNELS < 1) begin : g_chk_channels
        $error("multi_debouncer: CHANNELS must be >= 1");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_chk_debounce
        $error("multi_debouncer: DEBOUNCE_CYCLES must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_chk_hold
        $error("multi_debouncer: HOLD_CYCLES must be >= 1");
    end
    if (REPEAT_CYCLES < 1) begin : g_chk_repeat
        $error("multi_debouncer: REPEAT_CYCLES must be >= 1");
    end

    function automatic logic [HW-1:0] hold_sat_inc(input logic [HW-1:0] v);
        return (v == HOLD_MAX) ? v : v + HW'(1);
    endfunction

    logic [CHANNELS-1:0] lvl;
    logic [CHANNELS-1:0] s0_q;
    logic [CHANNELS-1:0] s1_q;

    assign lvl = button_in ^ {CHANNELS{INVERT}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_q <= '0;
            s1_q <= '0;
        end else begin
            s0_q <= lvl;
            s1_q <= s0_q;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DW-1:0] deb_q, deb_d;
        logic [HW-1:0] hold_q, hold_d;
        logic          btn_q, btn_d;
        logic          press_q, press_d;
        logic          rel_q, rel_d;
        logic          long_q, long_d;
        logic          accept;

        always_comb begin
            deb_d   = deb_q;
            btn_d   = btn_q;
            accept  = 1'b0;
            hold_d  = hold_q;
            long_d  = 1'b0;

            if (s1_q[c] == btn_q) begin
                deb_d = '0;
            end else if (deb_q == DEB_LAST) begin
                accept = 1'b1;
                btn_d  = s1_q[c];
                deb_d  = '0;
            end else begin
                deb_d = deb_q + DW'(1);
            end

            press_d = accept & s1_q[c];
            rel_d   = accept & ~s1_q[c];

            // Hold count runs only over a settled pressed level; the release edge clears it.
            if (!btn_q || rel_d) begin
                hold_d = '0;
            end else begin
                hold_d = hold_sat_inc(hold_q);
                long_d = (hold_q == HOLD_LAST);
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                deb_q   <= '0;
                hold_q  <= '0;
                btn_q   <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
            end else begin
                deb_q   <= deb_d;
                hold_q  <= hold_d;
                btn_q   <= btn_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                long_q  <= long_d;
            end
        end

        assign btn_out[c]       = btn_q;
        assign press_pulse[c]   = press_q;
        assign release_pulse[c] = rel_q;
        assign long_pulse[c]    = long_q;

`ifdef DEBOUNCE_REPEAT_EN
        logic [RW-1:0] rep_q, rep_d;
        logic          rep_pulse_q, rep_pulse_d;

        // A saturated hold counter means the long press has already fired.
        always_comb begin
            rep_d       = '0;
            rep_pulse_d = 1'b0;
            if (btn_q && !rel_d && (hold_q == HOLD_MAX)) begin
                if (rep_q == REP_LAST) begin
                    rep_pulse_d = 1'b1;
                end else begin
                    rep_d = rep_q + RW'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rep_q       <= '0;
                rep_pulse_q <= 1'b0;
            end else begin
                rep_q       <= rep_d;
                rep_pulse_q <= rep_pulse_d;
            end
        end

        assign repeat_pulse[c] = rep_pulse_q;
`else
        assign repeat_pulse[c] = 1'b0;
`endif
    end

    assign any_active = |btn_out;

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed testbench for multi_debouncer (CHANNELS=4, DEBOUNCE=8, HOLD=20, REPEAT=5).
`timescale 1ns/1ps
module tb_multi_debouncer;

    localparam int CH   = 4;
    localparam int DEB  = 8;
    localparam int HOLD = 20;
    localparam int REP  = 5;

`ifdef DEBOUNCE_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [CH-1:0] bin;
    logic [CH-1:0] bin_al;

    logic [CH-1:0] btn, press, rel, lng, rpt;
    logic          any;
    logic [CH-1:0] btn_al, press_al, rel_al, lng_al, rpt_al;
    logic          any_al;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    multi_debouncer #(
        .CHANNELS(CH), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP), .ACTIVE_LOW_IN(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .button_in(bin),
        .btn_out(btn), .press_pulse(press), .release_pulse(rel),
        .long_pulse(lng), .repeat_pulse(rpt), .any_active(any)
    );

    multi_debouncer #(
        .CHANNELS(CH), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP), .ACTIVE_LOW_IN(1)
    ) dut_al (
        .clk(clk), .reset_n(reset_n), .button_in(bin_al),
        .btn_out(btn_al), .press_pulse(press_al), .release_pulse(rel_al),
        .long_pulse(lng_al), .repeat_pulse(rpt_al), .any_active(any_al)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [CH-1:0] e_btn, e_pr, e_rel;
        reset_n = 1'b0;
        bin     = 4'b1111;
        bin_al  = 4'b1111;
        repeat (5) tick();
        nvec++;
        if ({btn, press, rel, lng, rpt, any} !== '0) begin
            nerr++;
            $display("FAIL reset_hold: btn=%b press=%b rel=%b long=%b rep=%b any=%b, want all 0",
                     btn, press, rel, lng, rpt, any);
        end
        reset_n = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            e_btn = (k >= 10) ? 4'b1111 : 4'b0000;
            e_pr  = (k == 10) ? 4'b1111 : 4'b0000;
            nvec++;
            if (btn !== e_btn || press !== e_pr || rel !== 4'b0000 || any !== (k >= 10)) begin
                nerr++;
                $display("FAIL reset_release k=%0d: btn=%b press=%b rel=%b any=%b, want btn=%b press=%b rel=0000 any=%0d",
                         k, btn, press, rel, any, e_btn, e_pr, (k >= 10));
            end
        end
        bin = 4'b0000;
        for (int k = 1; k <= 11; k++) begin
            tick();
            e_btn = (k < 10) ? 4'b1111 : 4'b0000;
            e_rel = (k == 10) ? 4'b1111 : 4'b0000;
            nvec++;
            if (btn !== e_btn || rel !== e_rel || press !== 4'b0000 || lng !== 4'b0000) begin
                nerr++;
                $display("FAIL reset_drop k=%0d: btn=%b rel=%b press=%b long=%b, want btn=%b rel=%b press=0000 long=0000",
                         k, btn, rel, press, lng, e_btn, e_rel);
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_glitch();
        bin = 4'b0001;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 7) bin = 4'b0000;
            nvec++;
            if ({btn[0], press[0], rel[0]} !== 3'b000) begin
                nerr++;
                $display("FAIL glitch k=%0d: btn0=%b press0=%b rel0=%b, want 0 0 0",
                         k, btn[0], press[0], rel[0]);
            end
        end
    endtask

    task automatic test_press_release();
        logic e_btn, e_pr, e_rel;
        bin = 4'b0010;
        for (int k = 1; k <= 12; k++) begin
            tick();
            e_btn = (k >= 10);
            e_pr  = (k == 10);
            nvec++;
            if (btn[1] !== e_btn || press[1] !== e_pr || rel[1] !== 1'b0 || lng[1] !== 1'b0) begin
                nerr++;
                $display("FAIL press1 k=%0d: btn1=%b press1=%b rel1=%b long1=%b, want %b %b 0 0",
                         k, btn[1], press[1], rel[1], lng[1], e_btn, e_pr);
            end
        end
        bin = 4'b0000;
        for (int k = 1; k <= 12; k++) begin
            tick();
            e_btn = (k < 10);
            e_rel = (k == 10);
            nvec++;
            if (btn[1] !== e_btn || rel[1] !== e_rel || press[1] !== 1'b0 || lng[1] !== 1'b0) begin
                nerr++;
                $display("FAIL release1 k=%0d: btn1=%b rel1=%b press1=%b long1=%b, want %b %b 0 0",
                         k, btn[1], rel[1], press[1], lng[1], e_btn, e_rel);
            end
        end
    endtask

    task automatic test_long_press();
        logic e_btn, e_pr, e_rel, e_lng, e_rpt;
        bin = 4'b0100;
        for (int k = 1; k <= 72; k++) begin
            tick();
            e_btn = (k >= 10) && (k < 68);
            e_pr  = (k == 10);
            e_rel = (k == 68);
            e_lng = (k == 30);
            e_rpt = REP_EN && (k > 30) && (k < 68) && (((k - 30) % REP) == 0);
            nvec++;
            if (btn[2] !== e_btn || press[2] !== e_pr || rel[2] !== e_rel ||
                lng[2] !== e_lng || rpt[2] !== e_rpt) begin
                nerr++;
                $display("FAIL long2 k=%0d: btn=%b press=%b rel=%b long=%b rep=%b, want %b %b %b %b %b",
                         k, btn[2], press[2], rel[2], lng[2], rpt[2],
                         e_btn, e_pr, e_rel, e_lng, e_rpt);
            end
            if (k == 58) bin = 4'b0000;
        end
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        logic [CH-1:0] e_btn, e_pr, e_rel;
        bin = 4'b1001;
        for (int k = 1; k <= 12; k++) begin
            tick();
            e_btn = (k >= 10) ? 4'b1001 : 4'b0000;
            e_pr  = (k == 10) ? 4'b1001 : 4'b0000;
            nvec++;
            if (btn !== e_btn || press !== e_pr || any !== (k >= 10)) begin
                nerr++;
                $display("FAIL concur_press k=%0d: btn=%b press=%b any=%b, want %b %b %0d",
                         k, btn, press, any, e_btn, e_pr, (k >= 10));
            end
        end
        bin = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            tick();
            e_btn = (k < 10) ? 4'b1001 : 4'b0001;
            e_rel = (k == 10) ? 4'b1000 : 4'b0000;
            nvec++;
            if (btn !== e_btn || rel !== e_rel) begin
                nerr++;
                $display("FAIL ch3_release k=%0d: btn=%b rel=%b, want %b %b", k, btn, rel, e_btn, e_rel);
            end
        end
        bin = 4'b1001;
        repeat (7) tick();
        reset_n = 1'b0;
        #2;
        nvec++;
        if ({btn, press, rel, lng, rpt, any} !== '0) begin
            nerr++;
            $display("FAIL async_reset: btn=%b press=%b rel=%b long=%b rep=%b any=%b, want all 0",
                     btn, press, rel, lng, rpt, any);
        end
        tick();
        reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            e_btn = (k >= 10) ? 4'b1001 : 4'b0000;
            e_pr  = (k == 10) ? 4'b1001 : 4'b0000;
            nvec++;
            if (btn !== e_btn || press !== e_pr || rel !== 4'b0000 || lng !== 4'b0000) begin
                nerr++;
                $display("FAIL requalify k=%0d: btn=%b press=%b rel=%b long=%b, want %b %b 0000 0000",
                         k, btn, press, rel, lng, e_btn, e_pr);
            end
        end
        bin = 4'b0000;
        for (int k = 1; k <= 12; k++) begin
            tick();
            e_btn = (k < 10) ? 4'b1001 : 4'b0000;
            e_rel = (k == 10) ? 4'b1001 : 4'b0000;
            nvec++;
            if (btn !== e_btn || rel !== e_rel || press !== 4'b0000) begin
                nerr++;
                $display("FAIL concur_release k=%0d: btn=%b rel=%b press=%b, want %b %b 0000",
                         k, btn, rel, press, e_btn, e_rel);
            end
        end
    endtask

    task automatic test_active_low();
        logic [CH-1:0] e_btn, e_pr;
        nvec++;
        if (btn_al !== 4'b0000 || any_al !== 1'b0) begin
            nerr++;
            $display("FAIL al_idle: btn=%b any=%b, want 0000 0", btn_al, any_al);
        end
        bin_al = 4'b1110;
        for (int k = 1; k <= 11; k++) begin
            tick();
            e_btn = (k >= 10) ? 4'b0001 : 4'b0000;
            e_pr  = (k == 10) ? 4'b0001 : 4'b0000;
            nvec++;
            if (btn_al !== e_btn || press_al !== e_pr || any_al !== (k >= 10) ||
                rel_al !== 4'b0000 || lng_al !== 4'b0000 || rpt_al !== 4'b0000) begin
                nerr++;
                $display("FAIL al_press k=%0d: btn=%b press=%b any=%b rel=%b long=%b rep=%b, want %b %b %0d 0000 0000 0000",
                         k, btn_al, press_al, any_al, rel_al, lng_al, rpt_al, e_btn, e_pr, (k >= 10));
            end
        end
        bin_al = 4'b1111;
        repeat (12) tick();
        nvec++;
        if (btn_al !== 4'b0000 || any_al !== 1'b0) begin
            nerr++;
            $display("FAIL al_release: btn=%b any=%b, want 0000 0", btn_al, any_al);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_glitch();
        test_press_release();
        test_long_press();
        test_back_to_back();
        test_active_low();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
